// File: rtl/rob_tag_scheduler.sv
// -----------------------------------------------------------------------------
// rob_tag_scheduler
//
// Reorder buffer that hands out tags at issue, collects results at writeback,
// and retires entries strictly in order toward the register file.
//
// Parameters
//   ROB_WIDTH   tag width; the buffer holds ROB_SIZE = 2**ROB_WIDTH entries
//   DATA_WIDTH  result value width
//
// Ports
//   clk_in            system clock, all state on posedge
//   rst_in            asynchronous active-high reset
//   rdy_in            global ready; low freezes all state
//   flush_in          (only with `define ROB_FLUSH_EN) discard all entries
//   issue_valid/rd    issue request and its destination register
//   issue_ready/tag   accept indication and the tag being allocated
//   rf_instr_signal   register-file retag strobe (combinational), with
//   rf_rd_id/rd_tag   the register being retagged and its new tag
//   wb_valid/tag/value  result writeback
//   rf_commit_signal  registered one-cycle commit pulse, with
//   rf_commit_tag/value the retiring tag and its result
//   count             number of occupied entries
//
// Optional feature: define ROB_FLUSH_EN to compile in the flush_in port.
// -----------------------------------------------------------------------------
module rob_tag_scheduler #(
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
`ifdef ROB_FLUSH_EN
  input  logic                  flush_in,
`endif
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,
  output logic [ROB_WIDTH-1:0]  issue_tag,
  output logic                  rf_instr_signal,
  output logic [4:0]            rf_rd_id,
  output logic [ROB_WIDTH-1:0]  rf_rd_tag,
  input  logic                  wb_valid,
  input  logic [ROB_WIDTH-1:0]  wb_tag,
  input  logic [DATA_WIDTH-1:0] wb_value,
  output logic                  rf_commit_signal,
  output logic [ROB_WIDTH-1:0]  rf_commit_tag,
  output logic [DATA_WIDTH-1:0] rf_commit_value,
  output logic [ROB_WIDTH:0]    count
);

  localparam int ROB_SIZE = 2 ** ROB_WIDTH;

  // Entry status bits, kept as vectors so they can be cleared in one shot.
  logic [ROB_SIZE-1:0]   busy_q, busy_d;
  logic [ROB_SIZE-1:0]   ready_q, ready_d;
  logic [4:0]            rd_q    [ROB_SIZE];
  logic [DATA_WIDTH-1:0] value_q [ROB_SIZE];

  logic [ROB_WIDTH-1:0]  head_q, head_d;
  logic [ROB_WIDTH-1:0]  tail_q, tail_d;
  logic [ROB_WIDTH:0]    count_q, count_d;

  logic                  commit_sig_q;
  logic [ROB_WIDTH-1:0]  commit_tag_q;
  logic [DATA_WIDTH-1:0] commit_value_q;

  logic flush_blk;   // flush_in as seen combinationally (blocks issue)
  logic flush;       // flush that actually takes effect this edge
`ifdef ROB_FLUSH_EN
  assign flush_blk = flush_in;
  assign flush     = flush_in & rdy_in;
`else
  assign flush_blk = 1'b0;
  assign flush     = 1'b0;
`endif

  logic accept;
  logic commit;
  logic wb_hit;

  // issue_ready looks at the current count only, so a full buffer refuses
  // issue even in a cycle where the head is retiring.
  assign issue_ready = (count_q < (ROB_WIDTH+1)'(ROB_SIZE)) & rdy_in & ~flush_blk;
  assign issue_tag   = tail_q;
  assign accept      = issue_valid & issue_ready;

  assign rf_instr_signal = accept & (issue_rd != 5'd0);
  assign rf_rd_id        = issue_rd;
  assign rf_rd_tag       = tail_q;

  // Commit looks at the registered ready bit, so a writeback to the head
  // cannot retire in the same cycle it arrives.
  assign commit = rdy_in & ~flush & busy_q[head_q] & ready_q[head_q];
  assign wb_hit = rdy_in & ~flush & wb_valid & busy_q[wb_tag];

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (ROB_WIDTH+1)'(accept) - (ROB_WIDTH+1)'(commit);

    if (wb_hit) ready_d[wb_tag] = 1'b1;

    if (commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + ROB_WIDTH'(1);
    end

    // An accepted issue never targets the head slot being retired: tail
    // equals head only when the buffer is empty (no commit) or full (no issue).
    if (accept) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + ROB_WIDTH'(1);
    end

    if (flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_sig_q   <= 1'b0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
    end else if (rdy_in) begin
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_sig_q <= commit & (rd_q[head_q] != 5'd0);
      if (commit) begin
        commit_tag_q   <= head_q;
        commit_value_q <= value_q[head_q];
      end
    end else begin
      // Frozen cycle: state holds, but the commit pulse must still drop.
      commit_sig_q <= 1'b0;
    end
  end

  // NOTE: the rd/value storage is deliberately not reset; an entry's payload
  // is only ever read while its busy bit is set, and busy is reset above.
  always_ff @(posedge clk_in) begin
    if (accept) rd_q[tail_q]    <= issue_rd;
    if (wb_hit) value_q[wb_tag] <= wb_value;
  end

  assign rf_commit_signal = commit_sig_q;
  assign rf_commit_tag    = commit_tag_q;
  assign rf_commit_value  = commit_value_q;
  assign count            = count_q;

endmodule

// File: tb/tb_rob_tag_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rob_tag_scheduler
//
// Self-checking bench for rob_tag_scheduler (default parameters). A vector
// table walks the basic issue/writeback/commit scenarios, hand-written
// sequences cover full-buffer wrap, mid-operation reset and (with
// ROB_FLUSH_EN) flush, and a randomized phase compares against a queue-based
// in-order retirement model.
// -----------------------------------------------------------------------------
module tb_rob_tag_scheduler;

  localparam int RW = 4;
  localparam int DW = 32;
  localparam int RS = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_in;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic [RW-1:0] issue_tag;
  logic          rf_instr_signal;
  logic [4:0]    rf_rd_id;
  logic [RW-1:0] rf_rd_tag;
  logic          wb_valid;
  logic [RW-1:0] wb_tag;
  logic [DW-1:0] wb_value;
  logic          rf_commit_signal;
  logic [RW-1:0] rf_commit_tag;
  logic [DW-1:0] rf_commit_value;
  logic [RW:0]   count;

  rob_tag_scheduler #(.ROB_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
`ifdef ROB_FLUSH_EN
    .flush_in         (flush_in),
`endif
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .issue_ready      (issue_ready),
    .issue_tag        (issue_tag),
    .rf_instr_signal  (rf_instr_signal),
    .rf_rd_id         (rf_rd_id),
    .rf_rd_tag        (rf_rd_tag),
    .wb_valid         (wb_valid),
    .wb_tag           (wb_tag),
    .wb_value         (wb_value),
    .rf_commit_signal (rf_commit_signal),
    .rf_commit_tag    (rf_commit_tag),
    .rf_commit_value  (rf_commit_value),
    .count            (count)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit iv, input logic [4:0] rd, input bit wv,
                       input logic [RW-1:0] wt, input logic [DW-1:0] wval, input bit rdy);
    issue_valid = iv;
    issue_rd    = rd;
    wb_valid    = wv;
    wb_tag      = wt;
    wb_value    = wval;
    rdy_in      = rdy;
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 1);
    flush_in = 1'b0;
    rst_in   = 1'b1;
    tick();
    rst_in   = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit            iv;
    logic [4:0]    rd;
    bit            wv;
    logic [RW-1:0] wt;
    logic [DW-1:0] wval;
    bit            rdy;
    bit            e_ready;   // before the edge
    logic [RW-1:0] e_tag;
    bit            e_instr;
    logic [RW:0]   e_cnt;     // after the edge
    bit            e_csig;
    logic [RW-1:0] e_ctag;
    logic [DW-1:0] e_cval;
  } vec_t;

  function automatic vec_t mk(bit iv, logic [4:0] rd, bit wv, logic [RW-1:0] wt,
                              logic [DW-1:0] wval, bit rdy, bit er, logic [RW-1:0] et,
                              bit ei, logic [RW:0] ec, bit es, logic [RW-1:0] ect,
                              logic [DW-1:0] ecv);
    vec_t v;
    v.iv = iv; v.rd = rd; v.wv = wv; v.wt = wt; v.wval = wval; v.rdy = rdy;
    v.e_ready = er; v.e_tag = et; v.e_instr = ei;
    v.e_cnt = ec; v.e_csig = es; v.e_ctag = ect; v.e_cval = ecv;
    return v;
  endfunction

  vec_t vecs [23];

  // ---------------------------------------------------------- random model
  typedef struct {
    int            tag;
    int            rd;
    bit            rdy;
    logic [DW-1:0] val;
  } ent_t;

  ent_t          mq[$];
  ent_t          head_e;
  int            next_tag;
  bit            m_csig;
  int            m_ctag;
  logic [DW-1:0] m_cval;

  bit            r_iv, r_wv, r_rdy, r_acc, r_commit, r_exp_ready;
  logic [4:0]    r_rd;
  logic [RW-1:0] r_wt;
  logic [DW-1:0] r_wval;

  initial begin
    flush_in = 1'b0;
    rst_in   = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    #12;
    check("reset_count", count, 0);
    check("reset_csig", rf_commit_signal, 0);
    check("reset_ctag", rf_commit_tag, 0);
    check("reset_cval", rf_commit_value, 0);
    check("reset_issue_tag", issue_tag, 0);
    rst_in = 1'b0;
    #1;

    // iv rd wv wt wval rdy | ready tag instr | cnt csig ctag cval
    vecs[0]  = mk(1, 5, 0, 0, 0,          1, 1, 0, 1, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 32'h1234,   1, 1, 1, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,          1, 1, 1, 0, 0, 1, 0, 32'h1234);
    vecs[3]  = mk(1, 1, 0, 0, 0,          1, 1, 1, 1, 1, 0, 0, 32'h1234);
    vecs[4]  = mk(1, 2, 0, 0, 0,          1, 1, 2, 1, 2, 0, 0, 32'h1234);
    vecs[5]  = mk(1, 3, 0, 0, 0,          1, 1, 3, 1, 3, 0, 0, 32'h1234);
    vecs[6]  = mk(0, 0, 1, 3, 32'h33,     1, 1, 4, 0, 3, 0, 0, 32'h1234);
    vecs[7]  = mk(0, 0, 1, 2, 32'h22,     1, 1, 4, 0, 3, 0, 0, 32'h1234);
    vecs[8]  = mk(0, 0, 1, 1, 32'h11,     1, 1, 4, 0, 3, 0, 0, 32'h1234);
    vecs[9]  = mk(0, 0, 0, 0, 0,          1, 1, 4, 0, 2, 1, 1, 32'h11);
    vecs[10] = mk(0, 0, 0, 0, 0,          1, 1, 4, 0, 1, 1, 2, 32'h22);
    vecs[11] = mk(0, 0, 0, 0, 0,          1, 1, 4, 0, 0, 1, 3, 32'h33);
    vecs[12] = mk(0, 0, 0, 0, 0,          1, 1, 4, 0, 0, 0, 3, 32'h33);
    vecs[13] = mk(1, 0, 0, 0, 0,          1, 1, 4, 0, 1, 0, 3, 32'h33);
    vecs[14] = mk(0, 0, 1, 4, 32'h44,     1, 1, 5, 0, 1, 0, 3, 32'h33);
    vecs[15] = mk(0, 0, 0, 0, 0,          1, 1, 5, 0, 0, 0, 4, 32'h44);
    vecs[16] = mk(1, 7, 0, 0, 0,          1, 1, 5, 1, 1, 0, 4, 32'h44);
    vecs[17] = mk(0, 0, 1, 5, 32'h55,     1, 1, 6, 0, 1, 0, 4, 32'h44);
    vecs[18] = mk(0, 0, 0, 0, 0,          0, 0, 6, 0, 1, 0, 4, 32'h44);
    vecs[19] = mk(1, 9, 0, 0, 0,          0, 0, 6, 0, 1, 0, 4, 32'h44);
    vecs[20] = mk(0, 0, 0, 0, 0,          1, 1, 6, 0, 0, 1, 5, 32'h55);
    vecs[21] = mk(0, 0, 1, 9, 32'h99,     1, 1, 6, 0, 0, 0, 5, 32'h55);
    vecs[22] = mk(0, 0, 0, 0, 0,          1, 1, 6, 0, 0, 0, 5, 32'h55);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].iv, vecs[i].rd, vecs[i].wv, vecs[i].wt, vecs[i].wval, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_issue_ready", i), issue_ready, vecs[i].e_ready);
      check($sformatf("v%0d_issue_tag", i), issue_tag, vecs[i].e_tag);
      check($sformatf("v%0d_rf_instr", i), rf_instr_signal, vecs[i].e_instr);
      if (vecs[i].e_instr) check($sformatf("v%0d_rf_rd_tag", i), rf_rd_tag, vecs[i].e_tag);
      tick();
      check($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      check($sformatf("v%0d_csig", i), rf_commit_signal, vecs[i].e_csig);
      check($sformatf("v%0d_ctag", i), rf_commit_tag, vecs[i].e_ctag);
      check($sformatf("v%0d_cval", i), rf_commit_value, vecs[i].e_cval);
    end

    // ------------------------------------------ full buffer and tag wrap
    do_reset();
    for (int i = 0; i < RS; i++) begin
      drive(1, 5'(i + 1), 0, 0, 0, 1);
      #1;
      check($sformatf("fill%0d_ready", i), issue_ready, 1);
      check($sformatf("fill%0d_tag", i), issue_tag, i);
      tick();
    end
    check("full_count", count, RS);
    drive(1, 3, 0, 0, 0, 1);
    #1;
    check("full_issue_ready", issue_ready, 0);
    check("full_rf_instr", rf_instr_signal, 0);
    drive(1, 3, 1, 0, 32'hABCD, 1);
    tick();
    check("full_hold_count", count, RS);
    drive(1, 3, 0, 0, 0, 1);
    #1;
    check("full_commit_cycle_ready", issue_ready, 0);
    tick();
    check("full_commit_csig", rf_commit_signal, 1);
    check("full_commit_ctag", rf_commit_tag, 0);
    check("full_commit_cval", rf_commit_value, 32'hABCD);
    check("full_commit_count", count, RS - 1);
    check("wrap_issue_ready", issue_ready, 1);
    check("wrap_issue_tag", issue_tag, 0);
    check("wrap_rf_rd_tag", rf_rd_tag, 0);
    tick();
    check("wrap_refill_count", count, RS);

    // ------------------------------------------------ reset mid-operation
    drive(0, 0, 1, 1, 32'h77, 1);
    tick();                       // entry 1 (now head) is ready
    drive(0, 0, 0, 0, 0, 1);
    rst_in = 1'b1;
    #1;
    check("midrst_async_count", count, 0);
    check("midrst_async_csig", rf_commit_signal, 0);
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("midrst_post%0d_csig", i), rf_commit_signal, 0);
      check($sformatf("midrst_post%0d_count", i), count, 0);
    end
    check("midrst_issue_tag", issue_tag, 0);

`ifdef ROB_FLUSH_EN
    // -------------------------------------------------------------- flush
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(i + 2), 0, 0, 0, 1);
      tick();
    end
    drive(0, 0, 1, 1, 32'h1, 1);
    tick();
    drive(0, 0, 1, 2, 32'h2, 1);
    tick();
    check("flush_pre_count", count, 5);
    drive(1, 4, 1, 0, 32'h3, 1);
    flush_in = 1'b1;
    #1;
    check("flush_issue_ready", issue_ready, 0);
    tick();
    flush_in = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("flush_count", count, 0);
    check("flush_csig", rf_commit_signal, 0);
    check("flush_next_tag", issue_tag, 0);
    tick();
    check("flush_post_csig", rf_commit_signal, 0);
    check("flush_post_count", count, 0);
`endif

    // --------------------------------------------------- randomized phase
    do_reset();
    mq.delete();
    next_tag = 0;
    m_csig   = 0;
    m_ctag   = 0;
    m_cval   = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r_rdy  = ($urandom_range(7) != 0);
      r_iv   = $urandom_range(1);
      r_rd   = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      r_wv   = $urandom_range(1);
      if (mq.size() > 0 && $urandom_range(3) != 0)
        r_wt = RW'(mq[$urandom_range(mq.size() - 1)].tag);
      else
        r_wt = RW'($urandom_range(RS - 1));
      r_wval = $urandom;
      drive(r_iv, r_rd, r_wv, r_wt, r_wval, r_rdy);
      #1;

      r_exp_ready = r_rdy && (mq.size() < RS);
      r_acc       = r_iv && r_exp_ready;
      check("rnd_issue_ready", issue_ready, r_exp_ready);
      check("rnd_issue_tag", issue_tag, next_tag);
      check("rnd_rf_instr", rf_instr_signal, r_acc && (r_rd != 0));
      if (r_acc && r_rd != 0) begin
        check("rnd_rf_rd_id", rf_rd_id, r_rd);
        check("rnd_rf_rd_tag", rf_rd_tag, next_tag);
      end

      // In-order retirement: the oldest entry leaves once its result
      // arrived on an earlier edge; results landing now count next cycle.
      r_commit = r_rdy && (mq.size() > 0) && mq[0].rdy;
      if (r_commit) head_e = mq[0];
      if (r_rdy && r_wv)
        foreach (mq[k])
          if (mq[k].tag == int'(r_wt)) begin
            mq[k].rdy = 1'b1;
            mq[k].val = r_wval;
          end
      if (r_commit) begin
        void'(mq.pop_front());
        m_csig = (head_e.rd != 0);
        m_ctag = head_e.tag;
        m_cval = head_e.val;
      end else begin
        m_csig = 1'b0;
      end
      if (r_acc) begin
        mq.push_back('{tag: next_tag, rd: int'(r_rd), rdy: 1'b0, val: '0});
        next_tag = (next_tag + 1) % RS;
      end

      tick();
      check("rnd_count", count, mq.size());
      check("rnd_csig", rf_commit_signal, m_csig);
      check("rnd_ctag", rf_commit_tag, m_ctag);
      check("rnd_cval", rf_commit_value, m_cval);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rob_tag_scheduler.md
ROB_TAG_SCHEDULER -- requirements
Module: rob_tag_scheduler

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, tag width; ROB_SIZE = 2**ROB_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, result value width.
REQ-003 SHALL have port clk_in  input  1  single system clock; all state on posedge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  ready; low freezes all state.
REQ-006 SHALL have ports issue_valid input 1 and issue_rd input 5: issue request and its destination register.
REQ-007 SHALL have ports issue_ready output 1 and issue_tag output ROB_WIDTH: accept indication and allocated tag.
REQ-008 SHALL have ports rf_instr_signal output 1, rf_rd_id output 5, rf_rd_tag output ROB_WIDTH: register-file retag strobe, register, tag.
REQ-009 SHALL have ports wb_valid input 1, wb_tag input ROB_WIDTH, wb_value input DATA_WIDTH: result writeback.
REQ-010 SHALL have ports rf_commit_signal output 1, rf_commit_tag output ROB_WIDTH, rf_commit_value output DATA_WIDTH: register-file commit.
REQ-011 SHALL have port count output ROB_WIDTH+1: occupied entries.
REQ-012 SHALL have port flush_in input 1, present only with ROB_FLUSH_EN.

Function
REQ-013 SHALL hold per entry: busy, ready, rd (5b), value (DATA_WIDTH); head and tail pointers ROB_WIDTH wide, wrapping ROB_SIZE-1 -> 0.
REQ-014 issue_ready SHALL be combinational: count < ROB_SIZE and rdy_in (and not flush_in when compiled in); issue_tag SHALL equal tail.
REQ-015 Issue accept = issue_valid & issue_ready; on the edge: entry[tail] busy=1, ready=0, rd=issue_rd; tail+1.
REQ-016 rf_instr_signal SHALL be combinational = accept & (issue_rd != 0); rf_rd_id=issue_rd, rf_rd_tag=tail. x0 issues allocate an entry without retagging.
REQ-017 Writeback with wb_valid & busy[wb_tag] SHALL set ready=1 and store wb_value on the edge; writeback to non-busy entry SHALL be ignored.
REQ-018 Commit: on an edge with rdy_in and busy[head] & ready[head], SHALL clear busy/ready of head, head+1, and register rf_commit_tag=head, rf_commit_value=value[head], rf_commit_signal=(rd[head]!=0).
REQ-019 rf_commit_signal SHALL be a one-cycle pulse; 0 on any edge without a commit; at most one commit per cycle, strictly in order.
REQ-020 Writeback-to-commit latency SHALL be 2 edges minimum: ready visible the edge after writeback, commit pulse output the edge after that.
REQ-021 Simultaneous issue and commit SHALL leave count unchanged; issue_ready uses current count, so a full buffer rejects issue even when a commit occurs that cycle.
REQ-022 Simultaneous writeback and commit on different entries SHALL both take effect; writeback to the head entry in the same cycle SHALL not commit that cycle.
REQ-023 Issue into an entry freed by commit in the same cycle is impossible by REQ-021; issue and writeback to the same tag SHALL not occur (tag not busy) and writeback is ignored.
REQ-024 With rdy_in low, no state SHALL change and rf_commit_signal SHALL be 0 after the edge.

Reset
REQ-025 On rst_in high, asynchronously: all busy/ready=0, head=tail=0, count=0, rf_commit_signal=0, rf_commit_tag=0, rf_commit_value=0.
REQ-026 Reset mid-operation SHALL discard all in-flight entries; no commit pulse SHALL follow reset deassertion until a new issue and writeback.

Configuration
REQ-027 Macro ROB_FLUSH_EN SHALL compile in flush_in: flush_in & rdy_in on an edge clears all busy/ready, head=tail=count=0, rf_commit_signal=0, overriding issue, writeback and commit that cycle.
REQ-028 Without ROB_FLUSH_EN, flush_in SHALL be absent and the buffer drains only by commit or reset.

Verification
REQ-029 Reset, issue rd=5 -> issue_tag=0, rf_instr_signal=1, rf_rd_tag=0; wb tag0 value 0x1234 -> 2 edges later rf_commit_signal=1, tag=0, value=0x1234, count=0.
REQ-030 Issue 16 back-to-back (ROB_WIDTH=4) -> count=16, issue_ready=0; writeback tag0, commit -> issue_ready=1, next tag=0 (wrap).
REQ-031 Issue tags 0,1,2; writeback 2 then 1 then 0 -> commits in order 0,1,2 on consecutive cycles.
REQ-032 Issue rd=0, writeback -> rf_instr_signal=0, entry pops with rf_commit_signal=0, count decrements.
REQ-033 Hold rdy_in=0 with pending ready head -> no commit, count frozen; rdy_in=1 -> commit next edge.
REQ-034 ROB_FLUSH_EN: 5 entries, 2 ready, assert flush_in -> count=0, no commit pulse, next issue_tag=0.
